puf_soc_frame_disassembler: RTL and testbench

Receive-side counterpart of the SoC frame assembler. Accepts a byte stream carrying one 160-bit status frame, least significant byte first, and rebuilds the frame. Checks the padding and unpacks the PUF counter and status fields for the host-side logic, using a valid/ready handshake on both sides. It sits between the UART RX byte path and the host register block or scoreboard.

---
 rtl/puf_soc_frame_disassembler_pkg.sv | 37 +++
 rtl/puf_soc_frame_shift.sv | 41 ++++
 rtl/puf_soc_frame_disassembler.sv | 142 ++++++++++++++
 tb/tb_puf_soc_frame_disassembler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_soc_frame_disassembler_pkg.sv
// Shared frame layout for the PUF SoC status frame (assembler and disassembler).
// Holds the field offsets for both layouts, the byte count and the FSM state codes.
package puf_soc_frame_disassembler_pkg;

  localparam int FRAME_W = 160;
  localparam int NBYTES  = FRAME_W / 8;

  // Debug (full) layout, LSB upward
  localparam int DBG_CNT_LSER_LSB = 0;
  localparam int DBG_CNT0_LSB     = 32;
  localparam int DBG_CNT1_LSB     = 64;
  localparam int DBG_FULL0_BIT    = 96;
  localparam int DBG_FULL1_BIT    = 97;
  localparam int DBG_RO_LSB       = 98;
  localparam int DBG_FSM_LSB      = 114;
  localparam int DBG_SEL0_LSB     = 117;
  localparam int DBG_SEL1_LSB     = 121;
  localparam int DBG_RX_LSB       = 125;
  localparam int DBG_PAD_LSB      = 133;

  // Normal layout
  localparam int NRM_CNT_LSER_LSB = 0;
  localparam int NRM_FULL0_BIT    = 32;
  localparam int NRM_FULL1_BIT    = 33;
  localparam int NRM_PAD_LSB      = 34;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  function automatic logic pad_nonzero(input logic [FRAME_W-1:0] frame, input logic dbg);
    logic [FRAME_W-1:0] pad;
    pad = dbg ? (frame >> DBG_PAD_LSB) : (frame >> NRM_PAD_LSB);
    return |pad;
  endfunction

endpackage

// File: rtl/puf_soc_frame_shift.sv
// Byte shift register and byte counter for an LSB-first frame.
// Each loaded byte enters at the top, so after NBYTES loads byte 0 sits at bits [7:0].
module puf_soc_frame_shift #(
  parameter int FRAM_SIZE = 160,
  parameter int NBYTES    = FRAM_SIZE / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         load,
  input  logic [7:0]                   byte_in,
  output logic [FRAM_SIZE-1:0]         frame_next,
  output logic [$clog2(NBYTES+1)-1:0]  count,
  output logic                         last
);

  localparam int CNT_W = $clog2(NBYTES + 1);

  logic [FRAM_SIZE-1:0] frame_q;

  assign frame_next = {byte_in, frame_q[FRAM_SIZE-1:8]};
  assign last       = (count == CNT_W'(NBYTES - 1));

  // NOTE: the data register has no reset; every bit is overwritten before a frame is used,
  // so only the counter that decides framing needs a defined reset value.
  always_ff @(posedge clk) begin
    if (load) frame_q <= frame_next;
  end

  // NOTE: sequential state is always assigned with <= so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= load ? CNT_W'(1) : '0;
    end else if (load) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/puf_soc_frame_disassembler.sv
// Rebuilds a 160-bit PUF status frame from an LSB-first byte stream, checks padding,
// and presents the unpacked fields to the host with a valid/ready handshake.
module puf_soc_frame_disassembler
  import puf_soc_frame_disassembler_pkg::*;
#(
  parameter int CNT_BIT_SIZE = 32,
  parameter int MUX_LENGTH   = 16,
  parameter int FRAM_SIZE    = 160,
  parameter int TIMEOUT_CYC  = 1000,
  localparam int SEL_W       = $clog2(MUX_LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_op_mode,
  input  logic [7:0]              i_byte,
  input  logic                    i_byte_valid,
  output logic                    o_byte_ready,
  input  logic                    i_frame_ready,
  output logic                    o_frame_valid,
  output logic [CNT_BIT_SIZE-1:0] o_cnt_lser,
  output logic [CNT_BIT_SIZE-1:0] o_cnt_0,
  output logic [CNT_BIT_SIZE-1:0] o_cnt_1,
  output logic                    o_full_0,
  output logic                    o_full_1,
  output logic [MUX_LENGTH-1:0]   o_ro_bnk_en,
  output logic [2:0]              o_fsm_state,
  output logic [SEL_W-1:0]        o_sel_mux_0,
  output logic [SEL_W-1:0]        o_sel_mux_1,
  output logic [2*SEL_W-1:0]      o_rx_data,
  output logic                    o_err_pad,
  output logic                    o_err_timeout
);

  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]                     state;
  logic                           mode_q;
  logic [GAP_W-1:0]               gap_q;
  logic [FRAM_SIZE-1:0]           frame_next;
  logic [$clog2(NBYTES+1)-1:0]    byte_cnt;
  logic                           last_byte;
  logic                           accept;

  assign o_byte_ready  = (state != ST_HOLD);
  assign o_frame_valid = (state == ST_HOLD);
  assign accept        = i_byte_valid && o_byte_ready;

  // Counter is held clear while idle; a byte accepted in IDLE clears and loads to count 1.
  puf_soc_frame_shift #(
    .FRAM_SIZE (FRAM_SIZE),
    .NBYTES    (NBYTES)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == ST_IDLE),
    .load       (accept),
    .byte_in    (i_byte),
    .frame_next (frame_next),
    .count      (byte_cnt),
    .last       (last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      mode_q        <= 1'b0;
      gap_q         <= '0;
      o_err_pad     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_cnt_lser    <= '0;
      o_cnt_0       <= '0;
      o_cnt_1       <= '0;
      o_full_0      <= 1'b0;
      o_full_1      <= 1'b0;
      o_ro_bnk_en   <= '0;
      o_fsm_state   <= '0;
      o_sel_mux_0   <= '0;
      o_sel_mux_1   <= '0;
      o_rx_data     <= '0;
    end else begin
      o_err_pad     <= 1'b0;
      o_err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q <= i_op_mode;
            gap_q  <= '0;
            state  <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // An accepted byte takes priority over a timeout on the same edge.
          if (accept) begin
            gap_q <= '0;
            if (last_byte) begin
              if (pad_nonzero(frame_next, mode_q)) begin
                o_err_pad <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                state <= ST_HOLD;
                if (mode_q) begin
                  o_cnt_lser  <= frame_next[DBG_CNT_LSER_LSB +: CNT_BIT_SIZE];
                  o_cnt_0     <= frame_next[DBG_CNT0_LSB +: CNT_BIT_SIZE];
                  o_cnt_1     <= frame_next[DBG_CNT1_LSB +: CNT_BIT_SIZE];
                  o_full_0    <= frame_next[DBG_FULL0_BIT];
                  o_full_1    <= frame_next[DBG_FULL1_BIT];
                  o_ro_bnk_en <= frame_next[DBG_RO_LSB +: MUX_LENGTH];
                  o_fsm_state <= frame_next[DBG_FSM_LSB +: 3];
                  o_sel_mux_0 <= frame_next[DBG_SEL0_LSB +: SEL_W];
                  o_sel_mux_1 <= frame_next[DBG_SEL1_LSB +: SEL_W];
                  o_rx_data   <= frame_next[DBG_RX_LSB +: 2*SEL_W];
                end else begin
                  o_cnt_lser  <= frame_next[NRM_CNT_LSER_LSB +: CNT_BIT_SIZE];
                  o_cnt_0     <= '0;
                  o_cnt_1     <= '0;
                  o_full_0    <= frame_next[NRM_FULL0_BIT];
                  o_full_1    <= frame_next[NRM_FULL1_BIT];
                  o_ro_bnk_en <= '0;
                  o_fsm_state <= '0;
                  o_sel_mux_0 <= '0;
                  o_sel_mux_1 <= '0;
                  o_rx_data   <= '0;
                end
              end
            end
          end else if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
            o_err_timeout <= 1'b1;
            gap_q         <= '0;
            state         <= ST_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        ST_HOLD: begin
          if (i_frame_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_soc_frame_disassembler.sv
// Self-checking bench for puf_soc_frame_disassembler: directed scenarios plus random frames,
// with expected fields computed from a field-level frame model.
module tb_puf_soc_frame_disassembler;

  localparam int T = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_op_mode;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        i_frame_ready;
  logic        o_frame_valid;
  logic [31:0] o_cnt_lser, o_cnt_0, o_cnt_1;
  logic        o_full_0, o_full_1;
  logic [15:0] o_ro_bnk_en;
  logic [2:0]  o_fsm_state;
  logic [3:0]  o_sel_mux_0, o_sel_mux_1;
  logic [7:0]  o_rx_data;
  logic        o_err_pad, o_err_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] lser, c0, c1;
    logic        f0, f1;
    logic [15:0] ro;
    logic [2:0]  fsm;
    logic [3:0]  s0, s1;
    logic [7:0]  rx;
  } fields_t;

  puf_soc_frame_disassembler #(
    .CNT_BIT_SIZE (32),
    .MUX_LENGTH   (16),
    .FRAM_SIZE    (160),
    .TIMEOUT_CYC  (T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_op_mode     (i_op_mode),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .o_byte_ready  (o_byte_ready),
    .i_frame_ready (i_frame_ready),
    .o_frame_valid (o_frame_valid),
    .o_cnt_lser    (o_cnt_lser),
    .o_cnt_0       (o_cnt_0),
    .o_cnt_1       (o_cnt_1),
    .o_full_0      (o_full_0),
    .o_full_1      (o_full_1),
    .o_ro_bnk_en   (o_ro_bnk_en),
    .o_fsm_state   (o_fsm_state),
    .o_sel_mux_0   (o_sel_mux_0),
    .o_sel_mux_1   (o_sel_mux_1),
    .o_rx_data     (o_rx_data),
    .o_err_pad     (o_err_pad),
    .o_err_timeout (o_err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Frame image built straight from the field list of each layout
  function automatic logic [159:0] build(input fields_t f, input bit dbg);
    logic [159:0] fr;
    if (dbg) fr = {27'd0, f.rx, f.s1, f.s0, f.fsm, f.ro, f.f1, f.f0, f.c1, f.c0, f.lser};
    else     fr = {126'd0, f.f1, f.f0, f.lser};
    return fr;
  endfunction

  function automatic fields_t expect_of(input fields_t f, input bit dbg);
    fields_t e;
    e = f;
    if (!dbg) begin
      e.c0 = '0; e.c1 = '0; e.ro = '0; e.fsm = '0; e.s0 = '0; e.s1 = '0; e.rx = '0;
    end
    return e;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.lser = $urandom; f.c0 = $urandom; f.c1 = $urandom;
    f.f0 = 1'($urandom); f.f1 = 1'($urandom);
    f.ro = 16'($urandom); f.fsm = 3'($urandom);
    f.s0 = 4'($urandom); f.s1 = 4'($urandom); f.rx = 8'($urandom);
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input fields_t e);
    check({tag, ".cnt_lser"},  o_cnt_lser,  e.lser);
    check({tag, ".cnt_0"},     o_cnt_0,     e.c0);
    check({tag, ".cnt_1"},     o_cnt_1,     e.c1);
    check({tag, ".full_0"},    32'(o_full_0), 32'(e.f0));
    check({tag, ".full_1"},    32'(o_full_1), 32'(e.f1));
    check({tag, ".ro_bnk_en"}, 32'(o_ro_bnk_en), 32'(e.ro));
    check({tag, ".fsm_state"}, 32'(o_fsm_state), 32'(e.fsm));
    check({tag, ".sel_mux_0"}, 32'(o_sel_mux_0), 32'(e.s0));
    check({tag, ".sel_mux_1"}, 32'(o_sel_mux_1), 32'(e.s1));
    check({tag, ".rx_data"},   32'(o_rx_data), 32'(e.rx));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and returns #1 after the edge that accepts it
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_byte       = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && n < 200) begin
      tick();
      n++;
    end
    if (!o_byte_ready) check("byte_ready_wait", 32'(o_byte_ready), 32'd1);
    tick();
    i_byte_valid = 1'b0;
  endtask

  task automatic send_range(input logic [159:0] fr, input int first, input int last_k,
                            input int toggle_at, input int max_gap);
    for (int k = first; k <= last_k; k++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap)) tick();
      if (k == toggle_at) i_op_mode = ~i_op_mode;
      send_byte(fr[8*k +: 8]);
    end
  endtask

  // Sends a good frame, checks delivery one cycle after the last byte, then releases it
  task automatic deliver(input string tag, input fields_t f, input bit dbg,
                         input int toggle_at, input int max_gap);
    logic [159:0] fr;
    fr = build(f, dbg);
    i_op_mode     = dbg;
    i_frame_ready = 1'b1;
    send_range(fr, 0, 19, toggle_at, max_gap);
    check({tag, ".frame_valid"}, 32'(o_frame_valid), 32'd1);
    check({tag, ".byte_ready"},  32'(o_byte_ready),  32'd0);
    check({tag, ".no_err"},      32'({o_err_pad, o_err_timeout}), 32'd0);
    check_fields(tag, expect_of(f, dbg));
    tick();
    check({tag, ".released"}, 32'({o_frame_valid, o_byte_ready}), 32'b01);
  endtask

  initial begin
    fields_t f, zero_f, held;
    logic [159:0] fr;
    int seen, pulses;
    bit hold_ok;

    zero_f = '{default: '0};
    rst = 1'b1; i_op_mode = 1'b0; i_byte = '0; i_byte_valid = 1'b0; i_frame_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset.byte_ready",  32'(o_byte_ready),  32'd1);
    check("reset.frame_valid", 32'(o_frame_valid), 32'd0);
    check("reset.errs",        32'({o_err_pad, o_err_timeout}), 32'd0);
    check_fields("reset", zero_f);

    // Directed debug frame
    f = '{lser: 32'h11223344, c0: 32'hAABBCCDD, c1: 32'h01020304, f0: 1'b0, f1: 1'b1,
          ro: 16'h8001, fsm: 3'd5, s0: 4'd3, s1: 4'd12, rx: 8'hC3};
    deliver("dbg1", f, 1'b1, -1, 0);

    // Normal frame: fields not carried must drop to zero
    f.lser = 32'hDEADBEEF; f.f0 = 1'b1; f.f1 = 1'b0;
    held = expect_of(f, 1'b0);
    deliver("nrm1", f, 1'b0, -1, 0);

    // Bad padding: pulse, no delivery, fields held
    f  = rand_fields();
    fr = build(f, 1'b1);
    fr[140] = 1'b1;
    i_op_mode = 1'b1;
    send_range(fr, 0, 19, -1, 0);
    check("pad.err_pad",     32'(o_err_pad),     32'd1);
    check("pad.frame_valid", 32'(o_frame_valid), 32'd0);
    check_fields("pad.held", held);
    tick();
    check("pad.pulse_end", 32'({o_err_pad, o_frame_valid}), 32'd0);
    deliver("after_pad", rand_fields(), 1'b1, -1, 1);

    // Timeout after ten bytes and exactly T idle cycles
    f  = rand_fields();
    fr = build(f, 1'b1);
    i_op_mode = 1'b1;
    send_range(fr, 0, 9, -1, 0);
    seen = 0; pulses = 0;
    for (int i = 1; i <= T + 5; i++) begin
      tick();
      if (o_err_timeout) begin
        pulses++;
        if (seen == 0) seen = i;
      end
    end
    check("timeout.cycle",  32'(seen),   32'(T));
    check("timeout.pulses", 32'(pulses), 32'd1);
    check("timeout.valid",  32'(o_frame_valid), 32'd0);
    deliver("after_timeout", rand_fields(), 1'b1, -1, 0);

    // Gap of T-1 idle cycles is tolerated; the byte on the boundary edge wins
    f  = rand_fields();
    fr = build(f, 1'b1);
    i_op_mode = 1'b1;
    send_range(fr, 0, 9, -1, 0);
    pulses = 0;
    repeat (T - 1) begin
      tick();
      if (o_err_timeout) pulses++;
    end
    send_range(fr, 10, 19, -1, 0);
    check("gap.no_timeout", 32'(pulses), 32'd0);
    check("gap.valid",      32'(o_frame_valid), 32'd1);
    check_fields("gap", expect_of(f, 1'b1));
    tick();

    // Backpressure: frame held 50 cycles while bytes are offered
    f  = rand_fields();
    fr = build(f, 1'b1);
    i_op_mode = 1'b1;
    i_frame_ready = 1'b0;
    send_range(fr, 0, 19, -1, 0);
    i_byte = 8'hA5; i_byte_valid = 1'b1;
    hold_ok = 1'b1;
    repeat (50) begin
      tick();
      if (!(o_frame_valid && !o_byte_ready)) hold_ok = 1'b0;
    end
    check("hold.stable", 32'(hold_ok), 32'd1);
    check_fields("hold", expect_of(f, 1'b1));
    i_byte_valid = 1'b0; i_frame_ready = 1'b1;
    check("hold.still_valid", 32'(o_frame_valid), 32'd1);
    tick();
    check("hold.release", 32'({o_frame_valid, o_byte_ready}), 32'b01);
    deliver("after_hold", rand_fields(), 1'b0, -1, 0);

    // Reset mid-frame, then frames with i_op_mode toggled after byte 0
    fr = build(rand_fields(), 1'b1);
    i_op_mode = 1'b1;
    send_range(fr, 0, 7, -1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.state", 32'({o_frame_valid, o_byte_ready}), 32'b01);
    check_fields("midrst", zero_f);
    deliver("post_rst_dbg", rand_fields(), 1'b1, 9, 0);
    deliver("post_rst_nrm", rand_fields(), 1'b0, 5, 0);

    // Random frames with random inter-byte gaps
    for (int r = 0; r < 6; r++) begin
      deliver($sformatf("rand%0d", r), rand_fields(), 1'($urandom), -1, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
